// File: rtl/spi_pwm_config.sv
// SPI-slave register-write controller for the PWM peripheral.
// Receives 16-bit write frames (R/W, 7-bit address, 8-bit data, MSB first)
// on asynchronous SCLK/COPI/nCS pins, synchronises them into clk and
// commits the data byte into one of five 8-bit configuration registers.
module spi_pwm_config #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);

    localparam int NUM_REGS = 5;
    localparam int FW       = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READY,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic                   r_sclk_hist;
    logic                   r_ncs_hist;
    logic [FW-1:0]          r_flush;

    state_t     r_state;
    state_t     w_state_next;
    logic [15:0] r_shift;
    logic [4:0]  r_count;
    logic [7:0]  r_cfg [0:NUM_REGS-1];
    logic        r_wr_strobe;
    logic        r_frame_err;

    logic w_sclk;
    logic w_copi;
    logic w_ncs;
    logic w_sclk_rise;
    logic w_ncs_rise;
    logic w_ncs_fall;
    logic w_flushed;
    logic w_clear;
    logic w_shift_en;
    logic w_commit;
    logic w_frame_ok;
    logic [6:0] w_addr;
    logic w_wr_en;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi      = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_hist;
    assign w_ncs_rise  = w_ncs & ~r_ncs_hist;
    assign w_ncs_fall  = ~w_ncs & r_ncs_hist;
    assign w_flushed   = (r_flush == FW'(SYNC_STAGES));

    // Input synchronisers plus one history flop each for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '1;
            r_sclk_hist <= 1'b0;
            r_ncs_hist  <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_sclk_hist <= w_sclk;
            r_ncs_hist  <= w_ncs;
        end
    end

    // The ncs chain is preloaded high by reset, so its output only reflects
    // the real pin once SYNC_STAGES post-reset samples have flushed through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush <= '0;
        end else if (!w_flushed) begin
            r_flush <= r_flush + FW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and datapath controls; ncs rise wins over a same-cycle sclk edge.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_shift_en   = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_flushed && w_ncs) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (w_ncs_fall) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_ncs_rise) begin
                    w_state_next = ST_COMMIT;
                end else if (w_sclk_rise) begin
                    w_shift_en = 1'b1;
                end
            end
            ST_COMMIT: begin
                w_commit     = 1'b1;
                w_state_next = ST_READY;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Shift register and saturating bit counter (17 marks "too long").
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_shift_en) begin
            r_shift <= {r_shift[14:0], w_copi};
            if (r_count != 5'd17) begin
                r_count <= r_count + 5'd1;
            end
        end
    end

    assign w_frame_ok = (r_count == 5'd16);
    assign w_addr     = r_shift[14:8];
    assign w_wr_en    = w_commit & w_frame_ok & r_shift[15] & (w_addr <= MAX_ADDR);

    // Configuration register file, written only by a complete, in-range write frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cfg[i] <= 8'h00;
            end
        end else if (w_wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_addr == 7'(i)) begin
                    r_cfg[i] <= r_shift[7:0];
                end
            end
        end
    end

    // One-cycle status pulses, produced from the single COMMIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_strobe <= w_wr_en;
            r_frame_err <= w_commit & ~w_frame_ok;
        end
    end

    assign en_reg_out_7_0  = r_cfg[0];
    assign en_reg_out_15_8 = r_cfg[1];
    assign en_reg_pwm_7_0  = r_cfg[2];
    assign en_reg_pwm_15_8 = r_cfg[3];
    assign pwm_duty_cycle  = r_cfg[4];
    assign wr_strobe       = r_wr_strobe;
    assign frame_err       = r_frame_err;

endmodule

// File: tb/tb_spi_pwm_config.sv
// Testbench for spi_pwm_config: bit-bangs SPI frames, compares the register
// outputs and pulse counts against a frame-level reference model.
module tb_spi_pwm_config;

    localparam int         SYNC = 2;
    localparam logic [6:0] MAXA = 7'h04;
    localparam int         HALF = 4;   // sclk half period in clk cycles (clk/8)

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;
    logic       frame_err;

    spi_pwm_config #(
        .SYNC_STAGES (SYNC),
        .MAX_ADDR    (MAXA)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe),
        .frame_err       (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_strobe = 0;
    int n_err    = 0;
    int exp_strobe = 0;
    int exp_err    = 0;
    logic [7:0] exp_reg [0:4];

    // Count high cycles of each pulse output, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) n_strobe++;
        if (frame_err === 1'b1) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int idx);
        case (idx)
            0:       return en_reg_out_7_0;
            1:       return en_reg_out_15_8;
            2:       return en_reg_pwm_7_0;
            3:       return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s reg%0d", tag, i), 32'(dut_reg(i)), 32'(exp_reg[i]));
        end
        check($sformatf("%s wr_strobe count", tag), n_strobe, exp_strobe);
        check($sformatf("%s frame_err count", tag), n_err, exp_err);
    endtask

    // Frame-level reference: only an exact 16-bit write to a valid address lands.
    task automatic model_frame(input logic [31:0] v, input int nbits);
        logic [6:0] addr;
        addr = v[14:8];
        if (nbits != 16) begin
            exp_err++;
        end else if (v[15] && addr <= MAXA) begin
            exp_reg[addr] = v[7:0];
            exp_strobe++;
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [31:0] v, input int nbits);
        for (int b = nbits - 1; b >= 0; b--) begin
            copi = v[b];
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    // Sends one frame; with check_now, samples SYNC+3 clk after ncs rises.
    task automatic send_frame(input logic [31:0] v, input int nbits, input bit check_now);
        ncs = 1'b0;
        wait_clk(HALF);
        shift_bits(v, nbits);
        wait_clk(HALF);
        ncs = 1'b1;
        model_frame(v, nbits);
        $display("frame 0x%0h bits=%0d", v, nbits);
        if (check_now) begin
            wait_clk(SYNC + 3);
            check_all($sformatf("frame 0x%0h/%0d", v, nbits));
        end else begin
            wait_clk(SYNC + 2);
        end
    endtask

    initial begin
        int base_strobe;
        logic [7:0] d;
        logic [31:0] v;
        logic [31:0] mask;
        int nb;

        for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;

        // Reset then idle.
        wait_clk(5);
        check_all("in reset");
        rst_n = 1'b1;
        wait_clk(100);
        check_all("idle 100clk");

        // Valid writes.
        send_frame(32'h8480, 16, 1'b1);
        send_frame(32'h80FF, 16, 1'b1);
        send_frame(32'h8155, 16, 1'b1);

        // Dropped frames: read request and out-of-range address.
        send_frame(32'h0412, 16, 1'b1);
        send_frame(32'h8A33, 16, 1'b1);

        // Malformed frames, then a good write to the same register.
        send_frame(32'h082F, 12, 1'b1);
        send_frame({14'h0, 16'h82F0, 2'b11}, 18, 1'b1);
        send_frame(32'h82F0, 16, 1'b1);

        // Reset mid-frame: the remainder of the frame must be ignored.
        ncs = 1'b0;
        wait_clk(HALF);
        shift_bits(32'h83, 8);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
        wait_clk(3);
        check_all("mid-frame reset held");
        rst_n = 1'b1;
        shift_bits(32'hAA, 8);
        wait_clk(HALF);
        ncs = 1'b1;
        $display("frame 0x83AA cut by reset");
        wait_clk(SYNC + 3);
        check_all("after cut frame");
        send_frame(32'h83AA, 16, 1'b1);

        // Back-to-back writes at minimum ncs gap to all addresses.
        base_strobe = n_strobe;
        for (int a = 0; a < 5; a++) begin
            d = 8'($urandom_range(0, 255));
            send_frame({16'h0, 1'b1, 7'(a), d}, 16, 1'b0);
        end
        wait_clk(SYNC + 3);
        check_all("back-to-back");
        check("back-to-back strobe pulses", n_strobe - base_strobe, 5);

        // Randomized frames: mixed lengths, directions and addresses.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                nb = $urandom_range(8, 20);
            end else begin
                nb = 16;
            end
            if (nb == 16) begin
                v = {16'h0, ($urandom_range(0, 3) != 0), 7'($urandom_range(0, 7)),
                     8'($urandom_range(0, 255))};
            end else begin
                mask = (32'h1 << nb) - 32'h1;
                v = $urandom() & mask;
            end
            send_frame(v, nb, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
